// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the framed UART transmitter.
//   txState_e        : serializer state encoding
//   PAR_NONE/ODD/EVEN: parity-mode values for the PARITY parameter
//   DEF_CLKS_PER_BIT : 27 MHz clock / 115200 baud
//   parityBit()      : line level of the parity bit for a payload word
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } txState_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEF_CLKS_PER_BIT = 234;

  // Callers zero-extend narrower payloads; the extra zeros leave the XOR unchanged.
  function automatic logic parityBit(input logic [7:0] word, input int mode);
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous FIFO that queues words in front of the serializer.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (empties the FIFO)
//   push, pushData    : write request and word
//   pop, popData      : read request; popData shows the head word whenever !empty
//   full, empty       : occupancy flags
// A push on a full FIFO is taken when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      cnt;
  logic             doPush, doPop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// uart_tx_framed -- UART transmitter: start bit, DATA_BITS payload (LSB first),
// optional parity, STOP_BITS stop bits; each bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   tx_data    : payload word, captured on the accepting edge
//   tx_valid   : tx_data valid
//   tx_ready   : word accepted on an edge where tx_valid && tx_ready
//   tx_busy    : a frame is on the line or a word is queued
//   uart_tx    : serial line, idles high
// Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry queue in front
// of the serializer; queued frames then leave back-to-back.
// uart_tx is registered from the current state, so the line trails the state by
// one cycle: the start bit appears on the edge after acceptance.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 uart_tx
);

  // Parameter legality
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gBadClks
    $error("uart_tx_framed: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : gBadData
    $error("uart_tx_framed: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : gBadPar
    $error("uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_tx_framed: FIFO_DEPTH must be a power of two in 2..16");
  end

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int             IW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  txState_e             state, stateNext;
  logic [CW-1:0]        bitCnt;
  logic [IW-1:0]        dataIdx;
  logic                 stopIdx;
  logic [DATA_BITS-1:0] shReg;
  logic                 parBit;
  logic                 rdyEn;       // low through reset, high from the first edge after it
  logic                 lineActive;  // uart_tx currently shows a frame level

  logic                 bitEnd, lastStop, loadSlot, load, accept, lineNext;
  logic                 wordAvail;
  logic [DATA_BITS-1:0] wordIn;

  assign accept   = tx_valid && tx_ready;
  assign bitEnd   = (bitCnt == BIT_LAST);
  assign lastStop = (state == ST_STOP) && bitEnd && (stopIdx == STOP_LAST);
  // A new word may enter the serializer while idle or in the final stop-bit cycle.
  assign loadSlot = (state == ST_IDLE) || lastStop;
  assign load     = loadSlot && wordAvail;

`ifdef UART_TX_FIFO_EN
  logic                 fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic [DATA_BITS-1:0] fifoHead;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifoPush),
    .pushData(tx_data),
    .pop     (fifoPop),
    .popData (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  // An empty FIFO is bypassed so a word reaching an idle serializer keeps
  // the one-cycle latency; otherwise queued words go first.
  assign tx_ready  = rdyEn && !fifoFull;
  assign wordAvail = !fifoEmpty || accept;
  assign wordIn    = fifoEmpty ? tx_data : fifoHead;
  assign fifoPop   = loadSlot && !fifoEmpty;
  assign fifoPush  = accept && !(loadSlot && fifoEmpty);
  assign tx_busy   = lineActive || (state != ST_IDLE) || !fifoEmpty;
`else
  assign tx_ready  = rdyEn && (state == ST_IDLE);
  assign wordAvail = accept;
  assign wordIn    = tx_data;
  assign tx_busy   = lineActive || (state != ST_IDLE);
`endif

  always_comb begin
    stateNext = state;
    lineNext  = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (load) stateNext = ST_START;
      end
      ST_START: begin
        lineNext = 1'b0;
        if (bitEnd) stateNext = ST_DATA;
      end
      ST_DATA: begin
        lineNext = shReg[dataIdx];
        if (bitEnd && dataIdx == DATA_LAST)
          stateNext = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        lineNext = parBit;
        if (bitEnd) stateNext = ST_STOP;
      end
      ST_STOP: begin
        if (lastStop) stateNext = load ? ST_START : ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bitCnt     <= '0;
      dataIdx    <= '0;
      stopIdx    <= 1'b0;
      shReg      <= '0;
      parBit     <= 1'b0;
      uart_tx    <= 1'b1;
      lineActive <= 1'b0;
      rdyEn      <= 1'b0;
    end else begin
      rdyEn      <= 1'b1;
      state      <= stateNext;
      uart_tx    <= lineNext;
      lineActive <= (state != ST_IDLE);

      // One bit-period counter for every state; restarts on each state change.
      if (state == ST_IDLE || stateNext != state || bitEnd) bitCnt <= '0;
      else                                                   bitCnt <= bitCnt + 1'b1;

      if (stateNext != ST_DATA)              dataIdx <= '0;
      else if (state == ST_DATA && bitEnd)   dataIdx <= dataIdx + 1'b1;

      if (state == ST_STOP && bitEnd && stopIdx != STOP_LAST) stopIdx <= stopIdx + 1'b1;
      else if (stateNext != ST_STOP)                          stopIdx <= 1'b0;

      if (load) begin
        shReg  <= wordIn;
        parBit <= parityBit(8'(wordIn), PARITY);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed. Three instances run side by side:
//   dut0: 8N1, dut1: 7 bits even parity 2 stop, dut2: 8 bits odd parity 1 stop.
// A queue-based waveform model predicts uart_tx/tx_busy/tx_ready every cycle;
// directed tests add hand-computed literal expectations.
module tb_uart_tx_framed;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int ND    = 3;
  localparam int DEPTH = 4;
  localparam int QMAX  = 4096;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [ND-1:0] vld = '0;
  logic [7:0]    dat [ND];
  logic [ND-1:0] lineV, busyV, readyV;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1),
                   .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(readyV[0]), .tx_busy(busyV[0]), .uart_tx(lineV[0]));

  uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2),
                   .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[1][6:0]), .tx_valid(vld[1]),
    .tx_ready(readyV[1]), .tx_busy(busyV[1]), .uart_tx(lineV[1]));

  uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1),
                   .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(readyV[2]), .tx_busy(busyV[2]), .uart_tx(lineV[2]));

  function automatic int cfgBits(input int d);
    return (d == 1) ? 7 : 8;
  endfunction
  function automatic int cfgPar(input int d);
    case (d)
      1:       return PAR_EVEN;
      2:       return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction
  function automatic int cfgStops(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // ---------------- model: per-cycle expected line levels ----------------
  bit qLvl   [ND][0:QMAX-1];
  bit qStart [ND][0:QMAX-1];
  int qHead  [ND];
  int qTail  [ND];
  bit expLine [ND];
  bit expBusy [ND];
  bit expReady[ND];
  int accCnt  [ND];
  bit modelLive = 1'b0;

  task automatic appendFrame(input int d, input logic [7:0] w);
    bit lv[$];
    bit p;
    p = 1'b0;
    lv.push_back(1'b0);
    for (int i = 0; i < cfgBits(d); i++) begin
      lv.push_back(w[i]);
      p ^= w[i];
    end
    if (cfgPar(d) == PAR_EVEN)     lv.push_back(p);
    else if (cfgPar(d) == PAR_ODD) lv.push_back(!p);
    for (int i = 0; i < cfgStops(d); i++) lv.push_back(1'b1);
    foreach (lv[b])
      for (int c = 0; c < CPB; c++)
        if (qTail[d] < QMAX) begin
          qLvl[d][qTail[d]]   = lv[b];
          qStart[d][qTail[d]] = (b == 0 && c == 0);
          qTail[d]++;
        end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        qHead[d]    = qTail[d];
        expLine[d]  = 1'b1;
        expBusy[d]  = 1'b0;
        expReady[d] = 1'b0;
      end else begin
        bit acc, inFrame;
        int pend;
        acc = vld[d] && expReady[d];
        if (qHead[d] < qTail[d]) begin
          expLine[d] = qLvl[d][qHead[d]];
          inFrame    = 1'b1;
          qHead[d]++;
        end else begin
          expLine[d] = 1'b1;
          inFrame    = 1'b0;
        end
        if (acc) begin
          appendFrame(d, dat[d]);
          accCnt[d]++;
        end
        // Frames whose start bit is not next on the line are still waiting.
        pend = 0;
        for (int i = qHead[d] + 1; i < qTail[d]; i++) if (qStart[d][i]) pend++;
        expBusy[d]  = inFrame || (qHead[d] < qTail[d]);
        expReady[d] = FIFO_ON ? (pend < DEPTH) : (qHead[d] == qTail[d]);
      end
    end
    modelLive = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelLive)
      for (int d = 0; d < ND; d++) begin
        check($sformatf("uart_tx[%0d]", d),  32'(lineV[d]),  32'(expLine[d]));
        check($sformatf("tx_busy[%0d]", d),  32'(busyV[d]),  32'(expBusy[d]));
        check($sformatf("tx_ready[%0d]", d), 32'(readyV[d]), 32'(expReady[d]));
      end
  end

  // ---------------- stimulus ----------------
  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds tx_valid until the model sees the word accepted; returns on the
  // negedge after the accepting edge.
  task automatic send(input int d, input logic [7:0] w);
    int c0, t;
    c0 = accCnt[d];
    t = 0;
    dat[d] = w;
    vld[d] = 1'b1;
    while (accCnt[d] == c0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    vld[d] = 1'b0;
    if (accCnt[d] == c0) begin
      checks++;
      failures++;
      $display("FAIL send_timeout dut%0d word=0x%0h", d, w);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  gotA;
    logic [10:0] gotB;
    for (int d = 0; d < ND; d++) dat[d] = 8'h00;

    // Reset state
    waitNeg(3);
    check("reset_line",  32'(lineV),  32'h7);
    check("reset_busy",  32'(busyV),  32'h0);
    check("reset_ready", 32'(readyV), 32'h0);
    rst_n = 1'b1;
    waitNeg(1);
    check("ready_after_reset", 32'(readyV), 32'h7);
    waitNeg(2);

    // 8N1, 0xA5: sample each bit period in its middle
    send(0, 8'hA5);
    waitNeg(2);
    gotA[0] = lineV[0];
    for (int k = 1; k < 10; k++) begin
      waitNeg(4);
      gotA[k] = lineV[0];
    end
    check("a5_frame_bits", 32'(gotA), 32'h34A);
    waitNeg(2);
    check("a5_busy_cycle40", 32'(busyV[0]), 32'h1);
    check("a5_ready_idle",   32'(readyV[0]), 32'h1);
    waitNeg(1);
    check("a5_busy_cycle41", 32'(busyV[0]), 32'h0);
    waitNeg(3);

    // 7E2, 0x03: 11 bit periods, parity 0
    send(1, 8'h03);
    waitNeg(2);
    gotB[0] = lineV[1];
    for (int k = 1; k < 11; k++) begin
      waitNeg(4);
      gotB[k] = lineV[1];
    end
    check("7e2_frame_bits", 32'(gotB), 32'h606);
    waitNeg(2);
    check("7e2_busy_cycle44", 32'(busyV[1]), 32'h1);
    waitNeg(1);
    check("7e2_busy_cycle45", 32'(busyV[1]), 32'h0);
    waitNeg(3);

    // Odd parity: 0x01 -> 0, 0x00 -> 1 (parity is bit period 9)
    send(2, 8'h01);
    waitNeg(38);
    check("odd_par_0x01", 32'(lineV[2]), 32'h0);
    send(2, 8'h00);
    waitNeg(38);
    check("odd_par_0x00", 32'(lineV[2]), 32'h1);
    waitNeg(6);

    // tx_data changes right after acceptance: 0x3C must still go out
    send(0, 8'h3C);
    dat[0] = 8'hFF;
    waitNeg(10);
    check("hold_data_bit1", 32'(lineV[0]), 32'h0);
    waitNeg(35);

    // Reset in the middle of DATA bit 3, then a clean 0x5A
    send(0, 8'hA5);
    waitNeg(17);
    check("pre_reset_bit3", 32'(lineV[0]), 32'h0);
    rst_n = 1'b0;
    waitNeg(1);
    check("midreset_line", 32'(lineV[0]), 32'h1);
    check("midreset_busy", 32'(busyV[0]), 32'h0);
    rst_n = 1'b1;
    waitNeg(2);
    send(0, 8'h5A);
    waitNeg(45);

`ifdef UART_TX_FIFO_EN
    // Five pushes on consecutive cycles into a depth-4 FIFO
    dat[0] = 8'h11;
    vld[0] = 1'b1;
    waitNeg(1);
    dat[0] = 8'h22;
    waitNeg(1);
    dat[0] = 8'h33;
    waitNeg(1);
    dat[0] = 8'h44;
    check("fifo_ready_before_full", 32'(readyV[0]), 32'h1);
    waitNeg(1);
    dat[0] = 8'h55;
    waitNeg(1);
    vld[0] = 1'b0;
    check("fifo_ready_full", 32'(readyV[0]), 32'h0);
    check("fifo_busy_full",  32'(busyV[0]),  32'h1);
    waitNeg(36);
    check("b2b_last_stop", 32'(lineV[0]), 32'h1);
    check("b2b_ready_after_pop", 32'(readyV[0]), 32'h1);
    waitNeg(1);
    check("b2b_next_start", 32'(lineV[0]), 32'h0);
    waitNeg(170);
`endif

    waitNeg(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, clk cycles per serial bit (27 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame; legal 5..8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, entries of the input FIFO; power of two, 2..16; used only when UART_TX_FIFO_EN is defined.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port tx_data, input, DATA_BITS, payload word; bit 0 is sent first.
REQ-009 SHALL have port tx_valid, input, 1, tx_data is valid.
REQ-010 SHALL have port tx_ready, output, 1, the block accepts a word this cycle.
REQ-011 SHALL have port tx_busy, output, 1, a frame is on the line or a word is queued.
REQ-012 SHALL have port uart_tx, output, 1, serial line; idle level is high.

Function
REQ-013 A word SHALL be accepted only on a posedge clk where tx_valid and tx_ready are both 1; tx_data SHALL be captured at that edge, and later changes to tx_data SHALL NOT affect the frame.
REQ-014 The serializer SHALL use the states IDLE, START, DATA, PARITY and STOP, encoded per uart_pkg.
REQ-015 Transitions SHALL be: IDLE->START on a word available; START->DATA; DATA->DATA until bit DATA_BITS-1; then DATA->PARITY if PARITY!=0, else DATA->STOP; PARITY->STOP; STOP->IDLE after STOP_BITS bit periods.
REQ-016 Every bit period, including each stop bit, SHALL last exactly CLKS_PER_BIT cycles, timed by one bit counter of width $clog2(CLKS_PER_BIT) that restarts at 0 on every state change.
REQ-017 The line levels SHALL be: START drives 0, DATA drives captured bit n, STOP drives 1, IDLE drives 1.
REQ-018 In PARITY, uart_tx SHALL drive the XOR of the captured data bits when PARITY=2 (even), and the inverse of that XOR when PARITY=1 (odd).
REQ-019 Latency SHALL be one cycle: the start bit appears on uart_tx on the edge after acceptance.
REQ-020 Without the FIFO, tx_ready SHALL be 1 only in IDLE, and the line SHALL stay high for at least 1 cycle between frames.
REQ-021 tx_busy SHALL be 1 from the acceptance edge until the last stop-bit cycle has completed with no word pending.
REQ-022 Illegal parameter values SHALL stop elaboration through a generate-time $error.

Reset
REQ-023 While rst_n=0 at posedge clk, the block SHALL set uart_tx=1, tx_busy=0, tx_ready=0, state=IDLE, counters=0 and the FIFO to empty; tx_ready SHALL rise on the first edge with rst_n=1.
REQ-024 A reset mid-frame SHALL abort the frame; uart_tx SHALL go high on the reset edge and the partial word SHALL be discarded.

Configuration
REQ-025 With the macro UART_TX_FIFO_EN defined, a FIFO of FIFO_DEPTH entries SHALL sit in front of the serializer.
REQ-026 With UART_TX_FIFO_EN defined, tx_ready SHALL equal !full, and a simultaneous push and pop on a full FIFO SHALL be accepted.
REQ-027 With UART_TX_FIFO_EN defined, the serializer SHALL pop in the last cycle of the final stop bit, so queued frames go out back-to-back with zero idle cycles.
REQ-028 With UART_TX_FIFO_EN undefined, no FIFO logic SHALL be generated and REQ-020 SHALL apply.

Structure
REQ-029 The package uart_pkg SHALL hold the state enum typedef, the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the default CLKS_PER_BIT.
REQ-030 The FIFO SHALL be the sub-module uart_tx_fifo: synchronous, parameterised width and depth, with full and empty flags and pointers that wrap modulo FIFO_DEPTH.

Verification
REQ-031 The bench SHALL cover: CLKS_PER_BIT=4, 8N1, send 0xA5 -> 40 cycles on uart_tx: 0, then 1,0,1,0,0,1,0,1, then 1; tx_busy falls after cycle 40.
REQ-032 The bench SHALL cover: DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x03 -> parity bit 0, two stop bits, 11 bit periods in total.
REQ-033 The bench SHALL cover: PARITY=1, send 0x01 -> parity bit 0; send 0x00 -> parity bit 1.
REQ-034 The bench SHALL cover: change tx_data on the cycle after acceptance -> the original word is transmitted.
REQ-035 The bench SHALL cover: FIFO enabled, DEPTH=4, push 5 words on consecutive cycles -> tx_ready deasserts while the FIFO is full, and all words are serialized back-to-back with no idle gap.
REQ-036 The bench SHALL cover: rst_n pulsed low during the DATA bit 3 period -> uart_tx=1 and tx_busy=0 on the next edge, then a new 0x5A sends cleanly.
